// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: request, grant and shared-master signals between two requesters, the arbiter and one SPI master.
interface spi_arbiter_if;
  logic [1:0] req;
  logic [7:0] tx0_data;
  logic [7:0] tx1_data;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [1:0] err;
  logic [7:0] rx_data;
  logic [1:0] cs_n;
  logic       m_start;
  logic [7:0] m_tx_data;
  logic       m_done;
  logic [7:0] m_rx_data;
  modport slave (
    input  req, tx0_data, tx1_data, m_done, m_rx_data,
    output gnt, done, err, rx_data, cs_n, m_start, m_tx_data
  );
  modport master (
    output req, tx0_data, tx1_data, m_done, m_rx_data,
    input  gnt, done, err, rx_data, cs_n, m_start, m_tx_data
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master between two requesters with cs_n setup/hold framing.
// Define SPI_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles and flag it on err.
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 255
) (
  input logic          clock_in,
  input logic          rs,
  spi_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       abort_q, abort_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [1:0] sel;
  logic       win;
  logic       active;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] to_q, to_d;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif
  // on a tie the requester not served last wins; a lone request always wins
  assign win    = (bus.req[0] & bus.req[1]) ? ~last_q : bus.req[1];
  assign sel    = owner_q ? 2'b10 : 2'b01;
  assign active = state_q inside {SETUP, START, WAIT, HOLD};
  assign bus.gnt       = active ? sel : 2'b00;
  assign bus.cs_n      = active ? ~sel : 2'b11;
  assign bus.done      = (state_q == DONE) ? sel : 2'b00;
  assign bus.m_start   = state_q == START;
  assign bus.m_tx_data = tx_q;
  assign bus.rx_data   = rx_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err = (state_q == DONE && abort_q) ? sel : 2'b00;
`else
  assign bus.err = 2'b00;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    abort_d = abort_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: if (bus.req != 2'b00) begin
        state_d = SETUP;
        owner_d = win;
        last_d  = win;
        tx_d    = win ? bus.tx1_data : bus.tx0_data;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
      SETUP: begin
        cnt_d   = (cnt_q == 4'(CS_SETUP - 1)) ? '0 : cnt_q + 4'd1;
        state_d = (cnt_q == 4'(CS_SETUP - 1)) ? START : SETUP;
      end
      START: begin
        state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      WAIT: if (bus.m_done) begin
        state_d = HOLD;
        rx_d    = bus.m_rx_data;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      else if (to_q == 8'(TIMEOUT - 1)) begin
        state_d = HOLD;
        rx_d    = 8'h00;
        abort_d = 1'b1;
      end else begin
        to_d = to_q + 8'd1;
      end
`endif
      HOLD: begin
        cnt_d   = (cnt_q == 4'(CS_HOLD - 1)) ? '0 : cnt_q + 4'd1;
        state_d = (cnt_q == 4'(CS_HOLD - 1)) ? DONE : HOLD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_in or negedge rs)
    if (!rs) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clock_in or negedge rs)
    if (!rs) to_q <= '0;
    else to_q <= to_d;
`endif
endmodule
